// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter owner and single-outstanding instruction fetch sequencer
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   trap_valid_i / trap_vec_i         trap redirect (highest priority)
//   mret_valid_i / mret_epc_i         mret redirect
//   jump_i / jump_addr_i              branch/jump redirect (lowest priority)
//   imem_req_valid_o/_addr_o/_ready_i instruction-memory request channel
//   imem_resp_valid_i/_data_i         instruction-memory response (one-cycle pulse)
//   inst_valid_o/inst_o/inst_pc_o     held instruction towards decode
//   inst_ready_i                      decode consumes held instruction
//   pc_o                              current fetch PC
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trap_valid_i,
    input  logic [63:0] trap_vec_i,
    input  logic        mret_valid_i,
    input  logic [63:0] mret_epc_i,
    input  logic        jump_i,
    input  logic [63:0] jump_addr_i,
    output logic        imem_req_valid_o,
    output logic [63:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [63:0] inst_pc_o,
    input  logic        inst_ready_i,
    output logic [63:0] pc_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] inst_pc_q, inst_pc_d;

    logic        redirect;
    logic [63:0] redirect_target;

    assign redirect = trap_valid_i | mret_valid_i | jump_i;

    always_comb begin
        redirect_target = jump_addr_i;
        if (trap_valid_i) begin
            redirect_target = trap_vec_i;
        end else if (mret_valid_i) begin
            redirect_target = mret_epc_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        // A redirect always retargets the PC, whatever the state.
        if (redirect) begin
            pc_d = redirect_target;
        end

        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready_i) begin
                    state_d = S_WAIT;
                    // The accepted request targets the old PC; its data must be thrown away.
                    if (redirect) begin
                        kill_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_resp_valid_i) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = imem_resp_data_i;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                // Redirect wins over a same-cycle consume: the held instruction is dropped.
                if (redirect) begin
                    state_d = S_REQ;
                end else if (inst_ready_i) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            inst_q    <= 32'd0;
            inst_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // Handshake outputs come straight from the state register.
    assign imem_req_valid_o = (state_q == S_REQ);
    assign imem_req_addr_o  = pc_q;
    assign inst_valid_o     = (state_q == S_HOLD);
    assign inst_o           = inst_q;
    assign inst_pc_o        = inst_pc_q;
    assign pc_o             = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard testbench for fetch_sequencer
module tb_fetch_sequencer;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid, mret_valid, jump;
    logic [63:0] trap_vec, mret_epc, jump_addr;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc, pc;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_cons  = 0;
    int cyc     = 0;
    int lat     = 1;
    int mcnt    = 0;
    logic [63:0] maddr;

    logic [63:0] exp_req[$];
    logic [63:0] exp_ipc[$];
    logic [31:0] exp_idat[$];
    int          cons_cyc[$];

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .trap_valid_i     (trap_valid),
        .trap_vec_i       (trap_vec),
        .mret_valid_i     (mret_valid),
        .mret_epc_i       (mret_epc),
        .jump_i           (jump),
        .jump_addr_i      (jump_addr),
        .imem_req_valid_o (req_valid),
        .imem_req_addr_o  (req_addr),
        .imem_req_ready_i (req_ready),
        .imem_resp_valid_i(resp_valid),
        .imem_resp_data_i (resp_data),
        .inst_valid_o     (inst_valid),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc),
        .inst_ready_i     (inst_ready),
        .pc_o             (pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    // Memory model: response returns lat cycles after the accepting edge.
    initial forever begin
        @(negedge clk);
        if (req_valid && req_ready && !rst) begin
            maddr = req_addr;
            mcnt  = lat;
        end
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                resp_valid = 1'b1;
                resp_data  = mem_word(maddr);
            end
        end
    end

    // Monitor: checks every accepted request and every consumed instruction.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                n_acc++;
                if (exp_req.size() == 0) timeout("req_unexpected");
                else chk("req_addr", req_addr, exp_req.pop_front());
            end
            if (inst_valid && inst_ready && !(trap_valid || mret_valid || jump)) begin
                n_cons++;
                cons_cyc.push_back(cyc);
                if (exp_ipc.size() == 0) timeout("inst_unexpected");
                else begin
                    chk("inst_pc", inst_pc, exp_ipc.pop_front());
                    chk("inst", {32'd0, inst}, {32'd0, exp_idat.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cons(input int target);
        int k = 0;
        while (n_cons < target && k < 40) begin tick(); k++; end
        if (n_cons < target) timeout("wait_cons");
    endtask

    task automatic wait_acc(input int target);
        int k = 0;
        while (n_acc < target && k < 40) begin tick(); k++; end
        if (n_acc < target) timeout("wait_acc");
    endtask

    task automatic wait_hold();
        int k = 0;
        while (!inst_valid && k < 40) begin tick(); k++; end
        if (!inst_valid) timeout("wait_hold");
    endtask

    task automatic push_inst(input logic [63:0] a);
        exp_ipc.push_back(a);
        exp_idat.push_back(mem_word(a));
    endtask

    logic [63:0] save_pc;
    logic [31:0] save_inst;
    int          base;

    initial begin
        rst = 1'b1;
        trap_valid = 0; mret_valid = 0; jump = 0;
        trap_vec = '0; mret_epc = '0; jump_addr = '0;
        req_ready = 0; inst_ready = 0; resp_valid = 0; resp_data = '0;
        tick(); tick();
        chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_inst_pc", inst_pc, RST_PC);
        chk("rst_pc", pc, RST_PC);

        // Free run.
        exp_req.push_back(64'h8000_0000); exp_req.push_back(64'h8000_0004);
        exp_req.push_back(64'h8000_0008); exp_req.push_back(64'h8000_000C);
        push_inst(64'h8000_0000); push_inst(64'h8000_0004);
        push_inst(64'h8000_0008); push_inst(64'h8000_000C);
        req_ready = 1; inst_ready = 1;
        rst = 1'b0;
        chk("boot_req_valid", {63'd0, req_valid}, 64'd0);
        tick();
        chk("first_req_valid", {63'd0, req_valid}, 64'd1);
        chk("first_req_addr", req_addr, RST_PC);
        wait_cons(3);
        inst_ready = 0;
        if (cons_cyc.size() >= 3) begin
            chk("cycles_per_inst_a", 64'(cons_cyc[1] - cons_cyc[0]), 64'd3);
            chk("cycles_per_inst_b", 64'(cons_cyc[2] - cons_cyc[1]), 64'd3);
        end else timeout("free_run_count");

        // Back-pressure in HOLD.
        wait_hold();
        save_pc = inst_pc; save_inst = inst;
        chk("bp_inst_pc", save_pc, 64'h8000_000C);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_inst_valid", {63'd0, inst_valid}, 64'd1);
            chk("bp_inst_stable", {32'd0, inst}, {32'd0, save_inst});
            chk("bp_inst_pc_stable", inst_pc, save_pc);
            chk("bp_no_req", {63'd0, req_valid}, 64'd0);
        end
        inst_ready = 1; req_ready = 0;
        tick();
        inst_ready = 0;
        chk("bp_release_pc", pc, 64'h8000_0010);
        chk("bp_release_valid", {63'd0, inst_valid}, 64'd0);

        // Redirect while a response is pending.
        exp_req.push_back(64'h8000_0010);
        exp_req.push_back(64'h8000_1000);
        lat = 2;
        req_ready = 1;
        tick();
        jump = 1; jump_addr = 64'h8000_1000;
        tick();
        jump = 0; lat = 1;
        chk("rw_pc", pc, 64'h8000_1000);
        chk("rw_inst_valid_a", {63'd0, inst_valid}, 64'd0);
        tick();
        chk("rw_inst_valid_b", {63'd0, inst_valid}, 64'd0);
        chk("rw_req_valid", {63'd0, req_valid}, 64'd1);
        chk("rw_req_addr", req_addr, 64'h8000_1000);

        // Simultaneous redirects in HOLD with a same-cycle consume.
        wait_hold();
        chk("rh_inst_pc", inst_pc, 64'h8000_1000);
        chk("rh_inst", {32'd0, inst}, {32'd0, mem_word(64'h8000_1000)});
        base = n_cons;
        trap_valid = 1; trap_vec = 64'h8000_0100;
        mret_valid = 1; mret_epc = 64'h8000_0200;
        jump = 1; jump_addr = 64'h8000_0300;
        inst_ready = 1; req_ready = 0;
        tick();
        trap_valid = 0; mret_valid = 0; jump = 0; inst_ready = 0;
        chk("rh_dropped", {63'd0, inst_valid}, 64'd0);
        chk("rh_pc", pc, 64'h8000_0100);
        chk("rh_req_addr", req_addr, 64'h8000_0100);
        chk("rh_no_consume", 64'(n_cons), 64'(base));

        // Redirect in REQ without ready, then PC wrap.
        jump = 1; jump_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        jump = 0;
        chk("wr_req_valid", {63'd0, req_valid}, 64'd1);
        chk("wr_req_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_req.push_back(64'h0);
        push_inst(64'hFFFF_FFFF_FFFF_FFFC);
        req_ready = 1; inst_ready = 1;
        wait_cons(base + 1);
        inst_ready = 0; lat = 3;
        chk("wrap_pc", pc, 64'h0);

        // Asynchronous reset while a request is in flight.
        wait_acc(n_acc + 1);
        #1 rst = 1'b1;
        #1;
        chk("ar_req_valid", {63'd0, req_valid}, 64'd0);
        chk("ar_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("ar_inst", {32'd0, inst}, 64'd0);
        chk("ar_inst_pc", inst_pc, RST_PC);
        chk("ar_pc", pc, RST_PC);
        req_ready = 0;
        tick();
        rst = 1'b0; lat = 1;
        tick();
        chk("ar_restart_req", {63'd0, req_valid}, 64'd1);
        chk("ar_restart_addr", req_addr, RST_PC);
        tick();
        tick();
        chk("ar_stale_ignored", {63'd0, inst_valid}, 64'd0);
        chk("ar_still_req", {63'd0, req_valid}, 64'd1);
        exp_req.push_back(RST_PC);
        push_inst(RST_PC);
        base = n_cons;
        req_ready = 1; inst_ready = 1;
        wait_cons(base + 1);
        req_ready = 0; inst_ready = 0;
        tick();
        tick();
        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
        chk("inst_queue_empty", 64'(exp_ipc.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
